// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// req/ack handshake, strobes the ControlUnit and keeps a circular return-address stack.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic [15:0] PC,
    output logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic        mode,
    output logic        cu_enable,
    input  logic        pc_upd_valid,
    input  logic [1:0]  SrcPc,
    input  logic [15:0] branch_target,
    input  logic [15:0] jump_target,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    localparam int             PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);
    localparam logic [3:0]     OP_CALL  = 4'b1101;
    localparam logic [3:0]     OP_RET   = 4'b1110;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        ir;
    logic [15:0]        pc_inc;
    logic [15:0]        pc_nxt;
    logic [15:0]        ras [RAS_DEPTH];
    logic [PTR_W-1:0]   sp;
    logic [PTR_W-1:0]   top_ptr;
    logic [PTR_W:0]     count;
    logic [15:0]        ras_top;
    logic               ras_empty;
    logic               ras_full;
    logic               fetch_done;
    logic               upd;
    logic               is_call;
    logic               is_ret;

    assign imem_addr = PC;
    assign instr     = ir;
    assign opcode    = ir[15:12];
    assign mode      = ir[11];

    // An ack only counts while a request is actually outstanding.
    assign fetch_done = (state == FETCH) && imem_req && imem_ack;
    assign upd        = (state == EXEC) && pc_upd_valid;

    assign pc_inc    = PC + 16'd1;
    assign top_ptr   = sp - PTR_W'(1);
    assign ras_top   = ras[top_ptr];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == RAS_FULL);
    assign is_call   = (opcode == OP_CALL);
    assign is_ret    = (opcode == OP_RET) && (SrcPc == 2'b11);

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (fetch_done) state_nxt = ISSUE;
            ISSUE:   state_nxt = EXEC;
            EXEC:    if (pc_upd_valid) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Non-RET SrcPc=11 just peeks at the top; an empty RET falls through to PC+1.
    always_comb begin
        pc_nxt = pc_inc;
        case (SrcPc)
            2'b00:   pc_nxt = pc_inc;
            2'b01:   pc_nxt = branch_target;
            2'b10:   pc_nxt = jump_target;
            default: pc_nxt = (is_ret && ras_empty) ? pc_inc : ras_top;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FETCH;
            PC            <= RESET_PC;
            ir            <= 16'h0000;
            imem_req      <= 1'b0;
            cu_enable     <= 1'b0;
            sp            <= '0;
            count         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            imem_req  <= (state_nxt == FETCH);
            cu_enable <= (state_nxt == ISSUE);
            if (fetch_done) begin
                ir <= imem_rdata;
            end
            if (upd) begin
                PC <= pc_nxt;
                // A push into a full stack overwrites the oldest slot, which is the one at sp.
                if (is_call) begin
                    sp <= sp + PTR_W'(1);
                    if (ras_full) begin
                        ras_overflow <= 1'b1;
                    end else begin
                        count <= count + (PTR_W + 1)'(1);
                    end
                end else if (is_ret) begin
                    if (ras_empty) begin
                        ras_underflow <= 1'b1;
                    end else begin
                        sp    <= top_ptr;
                        count <= count - (PTR_W + 1)'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && upd && is_call) begin
            ras[sp] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a driver plays memory and the downstream
// PC resolver, while a monitor checks every cu_enable strobe against a scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic [15:0] PC;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        mode;
    logic        cu_enable;
    logic        pc_upd_valid;
    logic [1:0]  SrcPc;
    logic [15:0] branch_target;
    logic [15:0] jump_target;
    logic        ras_overflow;
    logic        ras_underflow;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   cu_cyc[$];

    instr_fetch_unit #(.RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .PC            (PC),
        .instr         (instr),
        .opcode        (opcode),
        .mode          (mode),
        .cu_enable     (cu_enable),
        .pc_upd_valid  (pc_upd_valid),
        .SrcPc         (SrcPc),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected fetch.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cu_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cu_enable", {16'h0, PC}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                logic [15:0] w;
                e = exp_q.pop_front();
                w = e.word;
                cu_cyc.push_back(cyc);
                chk("issue_pc", {16'h0, PC}, {16'h0, e.addr});
                chk("issue_instr", {16'h0, instr}, {16'h0, w});
                chk("issue_opcode_mode", {27'h0, opcode, mode}, {27'h0, w[15:12], w[11]});
            end
        end
    end

    // One full instruction: fetch (optionally with wait states) then resolve next PC.
    task automatic do_instr(input logic [15:0] addr, input logic [15:0] word, input int wait_n,
                            input logic [1:0] src, input logic [15:0] bt, input logic [15:0] jt);
        int n;
        exp_q.push_back('{addr: addr, word: word});
        if (wait_n > 0) begin
            // Decoy update request that must be ignored outside EXEC.
            pc_upd_valid = 1'b1;
            SrcPc        = 2'b10;
            jump_target  = 16'hDEAD;
        end
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (imem_req !== 1'b1) begin
            chk("req_timeout", {31'h0, imem_req}, 32'h1);
            return;
        end
        for (int i = 0; i < wait_n; i++) begin
            chk("wait_req", {31'h0, imem_req}, 32'h1);
            chk("wait_addr", {16'h0, imem_addr}, {16'h0, addr});
            @(posedge clk); #1;
        end
        imem_rdata = word;
        imem_ack   = 1'b1;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        chk("req_drop_after_ack", {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;
        SrcPc         = src;
        branch_target = bt;
        jump_target   = jt;
        pc_upd_valid  = 1'b1;
        @(posedge clk); #1;
        pc_upd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        imem_rdata    = 16'h0000;
        imem_ack      = 1'b0;
        pc_upd_valid  = 1'b0;
        SrcPc         = 2'b00;
        branch_target = 16'h0000;
        jump_target   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", {16'h0, PC}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_cu", {31'h0, cu_enable}, 32'h0);
        chk("rst_ir", {16'h0, instr}, 32'h0);
        chk("rst_flags", {30'h0, ras_overflow, ras_underflow}, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch.
        do_instr(16'h0000, 16'h1000, 0, 2'b00, 16'h0, 16'h0);
        do_instr(16'h0001, 16'h2000, 0, 2'b00, 16'h0, 16'h0);
        if (cu_cyc.size() >= 2) chk("cu_period", cu_cyc[1] - cu_cyc[0], 32'd3);
        else chk("cu_count_seq", cu_cyc.size(), 32'd2);

        // Wait states, then branch and jumps.
        do_instr(16'h0002, 16'h3000, 4, 2'b01, 16'h0040, 16'h0);
        do_instr(16'h0040, 16'h4000, 0, 2'b10, 16'h0, 16'h0100);
        do_instr(16'h0100, 16'h5000, 0, 2'b10, 16'h0, 16'h0010);

        // CALL at 0x0010 to 0x0200, RET back to 0x0011.
        do_instr(16'h0010, 16'hD000, 0, 2'b10, 16'h0, 16'h0200);
        do_instr(16'h0200, 16'hE800, 0, 2'b11, 16'h0, 16'h0);
        do_instr(16'h0011, 16'h0000, 0, 2'b10, 16'h0, 16'h0001);

        // Five CALLs overflow the 4-deep stack; five RETs drain it and underflow.
        do_instr(16'h0001, 16'hD000, 0, 2'b10, 16'h0, 16'h0002);
        do_instr(16'h0002, 16'hD000, 0, 2'b10, 16'h0, 16'h0003);
        do_instr(16'h0003, 16'hD000, 0, 2'b10, 16'h0, 16'h0004);
        do_instr(16'h0004, 16'hD000, 0, 2'b10, 16'h0, 16'h0005);
        chk("ovf_before", {31'h0, ras_overflow}, 32'h0);
        do_instr(16'h0005, 16'hD000, 0, 2'b10, 16'h0, 16'h0300);
        chk("ovf_after", {31'h0, ras_overflow}, 32'h1);
        do_instr(16'h0300, 16'hE000, 0, 2'b11, 16'h0, 16'h0);
        do_instr(16'h0006, 16'hE000, 0, 2'b11, 16'h0, 16'h0);
        do_instr(16'h0005, 16'hE000, 0, 2'b11, 16'h0, 16'h0);
        do_instr(16'h0004, 16'hE000, 0, 2'b11, 16'h0, 16'h0);
        chk("unf_before", {31'h0, ras_underflow}, 32'h0);
        do_instr(16'h0003, 16'hE000, 0, 2'b11, 16'h0, 16'h0);
        chk("unf_after", {31'h0, ras_underflow}, 32'h1);
        chk("ovf_sticky", {31'h0, ras_overflow}, 32'h1);
        do_instr(16'h0004, 16'h0000, 0, 2'b00, 16'h0, 16'h0);

        // Reset while a fetch to 0x0005 is pending, with a late ack in the same cycle.
        chk("pending_addr", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0005});
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h7000;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        chk("midrst_pc", {16'h0, PC}, 32'h0);
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        chk("midrst_cu", {31'h0, cu_enable}, 32'h0);
        chk("midrst_ir", {16'h0, instr}, 32'h0);
        chk("midrst_flags", {30'h0, ras_overflow, ras_underflow}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_cu", {31'h0, cu_enable}, 32'h0);

        // PC+1 wraps from 0xFFFF to 0x0000.
        do_instr(16'h0000, 16'h0000, 0, 2'b10, 16'h0, 16'hFFFF);
        do_instr(16'hFFFF, 16'h1234, 0, 2'b00, 16'h0, 16'h0);
        do_instr(16'h0000, 16'h2345, 0, 2'b00, 16'h0, 16'h0);
        chk("final_addr", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0001});

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the ControlUnit in the 16-bit RISC core. It owns the program counter and fetches one 16-bit instruction word per instruction from instruction memory over a request/acknowledge handshake. It presents `opcode`, `mode`, `PC` and a one-cycle `cu_enable` strobe to the ControlUnit, then waits for the next-PC decision. It also keeps a 4-entry return-address stack (RAS) for CALL/RET.

## Interface
- `RESET_PC`, default 16'h0000, PC value loaded on reset.
- `RAS_DEPTH`, default 4, number of return-address stack entries (power of two).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `imem_req` output 1: instruction read request; held high until acknowledged.
- `imem_addr` output 16: word address equal to PC; stable while `imem_req` is high.
- `imem_rdata` input 16: instruction word; valid in the `imem_ack` cycle.
- `imem_ack` input 1: read complete.
- `PC` output 16: address of the instruction currently held in IR.
- `instr` output 16: IR contents.
- `opcode` output 4: IR[15:12].
- `mode` output 1: IR[11].
- `cu_enable` output 1: one-cycle strobe marking a new valid instruction.
- `pc_upd_valid` input 1: downstream has resolved the next PC.
- `SrcPc` input 2: next-PC select. 00 = PC+1, 01 = `branch_target`, 10 = `jump_target`, 11 = RAS pop.
- `branch_target` input 16: taken-branch address.
- `jump_target` input 16: JMP/CALL address.
- `ras_overflow` output 1: sticky; a CALL was made with the RAS full.
- `ras_underflow` output 1: sticky; a RET was made with the RAS empty.

## Operation
- States: FETCH, ISSUE, EXEC.
- Reset (`rst_n`=0 at an edge) sets:
  - state = FETCH, PC = `RESET_PC`, IR = 16'h0000;
  - `cu_enable` = 0, RAS count = 0, both sticky flags = 0;
  - `imem_req` = 0 during the reset cycle.
- FETCH:
  - Drives `imem_req`=1 and `imem_addr`=PC.
  - On the `imem_ack` edge: IR <= `imem_rdata`, go to ISSUE.
  - Holds indefinitely without ack.
- ISSUE: exactly one cycle. `cu_enable`=1 and `opcode`/`mode`/`PC` reflect the new IR. Go to EXEC.
- EXEC:
  - `cu_enable`=0 and IR/PC are held.
  - On `pc_upd_valid`, PC is loaded per `SrcPc` and the state returns to FETCH.
  - `pc_upd_valid` is ignored in FETCH and ISSUE.
- PC+1 is modulo 2^16: 16'hFFFF -> 16'h0000.
- The RAS is updated on the `pc_upd_valid` edge, based on IR opcode.
- CALL (opcode 1101):
  - Pushes PC+1.
  - When full, overwrites the oldest entry (circular), count stays at `RAS_DEPTH`, `ras_overflow` <= 1.
  - Next PC comes from `SrcPc` as usual (normally 10).
- RET (opcode 1110) with `SrcPc`=11:
  - Pops the top entry into PC.
  - When empty, PC <= PC+1, count stays 0, `ras_underflow` <= 1.
- `SrcPc`=11 with an opcode other than RET: the top entry is read without popping.
- All other opcodes leave the RAS unchanged.
- Sticky flags clear only on reset.
- Reset mid-operation (any state, including an outstanding `imem_req`) aborts immediately. A late `imem_ack` arriving in the reset cycle is ignored.

## Timing
- Fetch latency: `cu_enable` rises in the cycle after the `imem_ack` edge. With same-cycle ack, `cu_enable` follows FETCH by exactly 1 cycle.
- Minimum instruction period is 3 cycles (FETCH, ISSUE, EXEC), reached with immediate ack and `pc_upd_valid` in the first EXEC cycle.
- `imem_req` deasserts in the cycle after the ack edge. It never stays high across two consecutive acks.
- `PC`, `opcode` and `mode` are stable from ISSUE through the end of EXEC. The ControlUnit may sample them on any edge in that window.
- The new PC appears on `imem_addr` in the FETCH cycle directly after the `pc_upd_valid` edge.
- All outputs are registered except `imem_addr`=PC and the IR field slices.

## Test plan
- Reset then sequential fetch:
  - Stimulus: release `rst_n`; memory acks immediately with words 16'h1000, 16'h2000; `SrcPc`=00.
  - Required: `imem_addr` shows 0 then 1; `cu_enable` pulses every 3 cycles; `opcode` shows 0001 then 0010.
- Memory wait states:
  - Stimulus: ack delayed 4 cycles.
  - Required: `imem_req` high for all 4 cycles with `imem_addr` stable; exactly one `cu_enable` pulse after the ack.
- Branch and jump:
  - Stimulus: `SrcPc`=01 with `branch_target`=16'h0040, then `SrcPc`=10 with `jump_target`=16'h0100.
  - Required: next `imem_addr` = 0040, then 0100.
- CALL/RET:
  - Stimulus: CALL at PC=16'h0010 to 16'h0200, then RET (`SrcPc`=11).
  - Required: after the RET, PC = 16'h0011.
- RAS boundaries:
  - Stimulus: 5 CALLs at PC = 1, 2, 3, 4, 5, then 5 RETs.
  - Required: `ras_overflow`=1; RETs return 6, 5, 4, 3; the 5th RET sets `ras_underflow`=1 and takes PC+1.
- Reset mid-fetch and wrap:
  - Stimulus: assert `rst_n`=0 while `imem_req` is pending, with an ack in the same cycle.
  - Required: PC = `RESET_PC`, no `cu_enable`, flags cleared.
  - Stimulus: PC = 16'hFFFF with `SrcPc`=00.
  - Required: next `imem_addr` = 16'h0000.
